// File: rtl/fft_out_collector.sv
// fft_out_collector
//   Captures one frame of N_POINTS complex FFT output samples into a buffer.
//   The buffer and control/status registers are reachable over a simple
//   memory-mapped port with registered reads.
//
// Ports
//   clk, reset_n      : clock, asynchronous active-low reset
//   out_valid_i       : FFT output strobe, one sample per high cycle
//   dout_r_i/dout_i_i : signed real/imag parts of the sample
//   en_i, we_i        : access enable, byte write enables (0 = read)
//   addr_i, data_i    : byte address, write data
//   data_o            : registered read data (holds between reads)
//   irq_o             : registered frame-done interrupt (DONE & IRQ_EN)
//
// Register map (byte address)
//   0x000 CTRL   : b0 ARM (pulse), b1 CLEAR (pulse), b2 IRQ_EN (r/w)
//   0x004 STATUS : b1:0 state, b2 DONE, b3 OVERFLOW
//   0x008 COUNT  : samples stored in the current frame
//   0x100+4k     : buffer entry k = {dout_r, dout_i} (read-only)
module fft_out_collector #(
    parameter int N_POINTS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        out_valid_i,
    input  logic [15:0] dout_r_i,
    input  logic [15:0] dout_i_i,
    input  logic        en_i,
    input  logic [3:0]  we_i,
    input  logic [9:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        irq_o
);

    localparam int AW = $clog2(N_POINTS);
    localparam int CW = AW + 1;   // COUNT must reach N_POINTS itself

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            irq_en_q, irq_en_d;
    logic            ctrl_wr, arm, clr;
    logic            wr_en;
    logic [31:0]     mem [N_POINTS];
    logic [31:0]     rd_data;
    logic [7:0]      buf_k;
    logic            unused_bits;

    assign unused_bits = ^{data_i[31:3], we_i[3:1], addr_i[1:0]};

    assign ctrl_wr = en_i && we_i[0] && (addr_i[9:2] == 8'd0);
    assign arm     = ctrl_wr && data_i[0];
    assign clr     = ctrl_wr && data_i[1];

    // Next-state: CLEAR beats ARM, and an accepted ARM/CLEAR swallows any
    // sample arriving in the same cycle without flagging overflow.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        irq_en_d = ctrl_wr ? data_i[2] : irq_en_q;
        if (clr) begin
            state_d = S_IDLE;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (arm && (state_q == S_IDLE || state_q == S_DONE)) begin
            state_d = S_ARMED;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (out_valid_i) begin
            case (state_q)
                S_ARMED: begin
                    wr_en   = 1'b1;
                    count_d = CW'(1);
                    state_d = S_CAPTURE;
                end
                S_CAPTURE: begin
                    wr_en   = 1'b1;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(N_POINTS - 1)) state_d = S_DONE;
                end
                default: ovf_d = 1'b1;   // IDLE or DONE: sample dropped
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            // Built from next-state values so irq_o lines up with DONE.
            irq_o    <= (state_d == S_DONE) && irq_en_d;
        end
    end

    // Buffer is not reset; in ARMED count_q is 0, so one index serves both.
    always_ff @(posedge clk) begin
        if (wr_en) mem[count_q[AW-1:0]] <= {dout_r_i, dout_i_i};
    end

    // Read mux sees pre-update state, so a same-cycle write returns old data.
    always_comb begin
        rd_data = '0;
        buf_k   = addr_i[9:2] - 8'd64;
        if (addr_i[9:8] != 2'b00) begin
            if ({24'b0, buf_k} < N_POINTS) rd_data = mem[buf_k[AW-1:0]];
        end else begin
            case (addr_i[9:2])
                8'd0:    rd_data = {29'b0, irq_en_q, 2'b00};
                8'd1:    rd_data = {28'b0, ovf_q, state_q == S_DONE, state_q};
                8'd2:    rd_data = 32'(count_q);
                default: rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                   data_o <= '0;
        else if (en_i && we_i == 4'b0)  data_o <= rd_data;
    end

endmodule

// File: tb/tb_fft_out_collector.sv
// Directed testbench for fft_out_collector (N_POINTS = 32).
// Inputs are driven 1 ns after the rising edge; outputs are sampled there too.
module tb_fft_out_collector;

    localparam logic [9:0] A_CTRL = 10'h000, A_STAT = 10'h004, A_CNT = 10'h008;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        out_valid_i = 1'b0;
    logic [15:0] dout_r_i = '0, dout_i_i = '0;
    logic        en_i = 1'b0;
    logic [3:0]  we_i = '0;
    logic [9:0]  addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        irq_o;
    logic [31:0] v;

    int vectors = 0;
    int errors  = 0;

    fft_out_collector #(.N_POINTS(32)) dut (
        .clk(clk), .reset_n(reset_n), .out_valid_i(out_valid_i),
        .dout_r_i(dout_r_i), .dout_i_i(dout_i_i), .en_i(en_i), .we_i(we_i),
        .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ent(input int k);
        return 10'(10'h100 + 4 * k);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        en_i = 1'b1; we_i = 4'hF; addr_i = a; data_i = d;
        tick(1);
        en_i = 1'b0; we_i = 4'h0;
    endtask

    task automatic rd(input logic [9:0] a, output logic [31:0] d);
        en_i = 1'b1; we_i = 4'h0; addr_i = a;
        tick(1);
        en_i = 1'b0;
        d = data_o;
    endtask

    task automatic sample(input logic [15:0] r, input logic [15:0] i);
        out_valid_i = 1'b1; dout_r_i = r; dout_i_i = i;
        tick(1);
        out_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(2);
        vectors++; if (data_o !== 32'h0) begin errors++; $display("FAIL rst_data_o got %h exp %h", data_o, 32'h0); end
        vectors++; if (irq_o !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp %b", irq_o, 1'b0); end
        reset_n = 1'b1;
        tick(1);
        rd(A_STAT, v); vectors++; if (v !== 32'h0) begin errors++; $display("FAIL rst_status got %h exp %h", v, 32'h0); end
        rd(A_CNT, v);  vectors++; if (v !== 32'h0) begin errors++; $display("FAIL rst_count got %h exp %h", v, 32'h0); end
        rd(A_CTRL, v); vectors++; if (v !== 32'h0) begin errors++; $display("FAIL rst_ctrl got %h exp %h", v, 32'h0); end
    endtask

    task automatic test_full_frame();
        wr(A_CTRL, 32'h5);
        rd(A_STAT, v); vectors++; if (v !== 32'h1) begin errors++; $display("FAIL full_armed got %h exp %h", v, 32'h1); end
        for (int k = 0; k < 32; k++) begin
            sample(16'(k), 16'(-k));
            if (k == 30) begin vectors++; if (irq_o !== 1'b0) begin errors++; $display("FAIL full_irq_early got %b exp %b", irq_o, 1'b0); end end
            if (k == 31) begin vectors++; if (irq_o !== 1'b1) begin errors++; $display("FAIL full_irq got %b exp %b", irq_o, 1'b1); end end
        end
        rd(A_STAT, v); vectors++; if (v !== 32'h7) begin errors++; $display("FAIL full_status got %h exp %h", v, 32'h7); end
        rd(A_CNT, v);  vectors++; if (v !== 32'd32) begin errors++; $display("FAIL full_count got %h exp %h", v, 32'd32); end
        rd(ent(31), v); vectors++; if (v !== 32'h001FFFE1) begin errors++; $display("FAIL full_e31 got %h exp %h", v, 32'h001FFFE1); end
        rd(ent(5), v);  vectors++; if (v !== 32'h0005FFFB) begin errors++; $display("FAIL full_e5 got %h exp %h", v, 32'h0005FFFB); end
        // buffer window is read-only; the write must also leave data_o alone
        wr(ent(5), 32'hFFFFFFFF);
        tick(1);
        vectors++; if (data_o !== 32'h0005FFFB) begin errors++; $display("FAIL hold_data_o got %h exp %h", data_o, 32'h0005FFFB); end
        rd(ent(5), v);  vectors++; if (v !== 32'h0005FFFB) begin errors++; $display("FAIL buf_wr_ignored got %h exp %h", v, 32'h0005FFFB); end
        rd(ent(40), v); vectors++; if (v !== 32'h0) begin errors++; $display("FAIL oob_entry got %h exp %h", v, 32'h0); end
        rd(10'h00C, v); vectors++; if (v !== 32'h0) begin errors++; $display("FAIL reserved got %h exp %h", v, 32'h0); end
        rd(A_CTRL, v);  vectors++; if (v !== 32'h4) begin errors++; $display("FAIL ctrl_irqen got %h exp %h", v, 32'h4); end
    endtask

    task automatic test_overflow();
        sample(16'h7777, 16'h7777);
        rd(A_STAT, v); vectors++; if (v !== 32'hF) begin errors++; $display("FAIL ovf_status got %h exp %h", v, 32'hF); end
        rd(A_CNT, v);  vectors++; if (v !== 32'd32) begin errors++; $display("FAIL ovf_count got %h exp %h", v, 32'd32); end
        rd(ent(0), v); vectors++; if (v !== 32'h0) begin errors++; $display("FAIL ovf_e0 got %h exp %h", v, 32'h0); end
    endtask

    task automatic test_abort();
        wr(A_CTRL, 32'h5);
        rd(A_STAT, v); vectors++; if (v !== 32'h1) begin errors++; $display("FAIL rearm_status got %h exp %h", v, 32'h1); end
        vectors++; if (irq_o !== 1'b0) begin errors++; $display("FAIL rearm_irq got %b exp %b", irq_o, 1'b0); end
        for (int k = 0; k < 10; k++) sample(16'(16'h0100 + k), 16'(16'h0200 + k));
        rd(A_STAT, v); vectors++; if (v !== 32'h2) begin errors++; $display("FAIL abort_capture got %h exp %h", v, 32'h2); end
        rd(A_CNT, v);  vectors++; if (v !== 32'd10) begin errors++; $display("FAIL abort_count10 got %h exp %h", v, 32'd10); end
        wr(A_CTRL, 32'h6);
        rd(A_STAT, v); vectors++; if (v !== 32'h0) begin errors++; $display("FAIL abort_status got %h exp %h", v, 32'h0); end
        rd(A_CNT, v);  vectors++; if (v !== 32'h0) begin errors++; $display("FAIL abort_count got %h exp %h", v, 32'h0); end
        sample(16'hDEAD, 16'hBEEF);
        rd(A_STAT, v); vectors++; if (v !== 32'h8) begin errors++; $display("FAIL abort_ovf got %h exp %h", v, 32'h8); end
        rd(ent(0), v); vectors++; if (v !== 32'h01000200) begin errors++; $display("FAIL abort_e0 got %h exp %h", v, 32'h01000200); end
        rd(ent(10), v); vectors++; if (v !== 32'h000AFFF6) begin errors++; $display("FAIL abort_e10 got %h exp %h", v, 32'h000AFFF6); end
        rd(A_CTRL, v); vectors++; if (v !== 32'h4) begin errors++; $display("FAIL abort_irqen got %h exp %h", v, 32'h4); end
    endtask

    task automatic test_priority();
        wr(A_CTRL, 32'h1);
        rd(A_STAT, v); vectors++; if (v !== 32'h1) begin errors++; $display("FAIL prio_armed got %h exp %h", v, 32'h1); end
        wr(A_CTRL, 32'h3);
        sample(16'h1234, 16'h5678);
        rd(A_STAT, v); vectors++; if (v !== 32'h8) begin errors++; $display("FAIL prio_status got %h exp %h", v, 32'h8); end
        rd(A_CNT, v);  vectors++; if (v !== 32'h0) begin errors++; $display("FAIL prio_count got %h exp %h", v, 32'h0); end
        rd(ent(0), v); vectors++; if (v !== 32'h01000200) begin errors++; $display("FAIL prio_e0 got %h exp %h", v, 32'h01000200); end
        // CLEAR coinciding with a sample: dropped, no overflow
        wr(A_CTRL, 32'h1);
        en_i = 1'b1; we_i = 4'hF; addr_i = A_CTRL; data_i = 32'h2;
        out_valid_i = 1'b1; dout_r_i = 16'h4321; dout_i_i = 16'h8765;
        tick(1);
        en_i = 1'b0; we_i = 4'h0; out_valid_i = 1'b0;
        rd(A_STAT, v); vectors++; if (v !== 32'h0) begin errors++; $display("FAIL clr_valid_status got %h exp %h", v, 32'h0); end
        rd(ent(0), v); vectors++; if (v !== 32'h01000200) begin errors++; $display("FAIL clr_valid_e0 got %h exp %h", v, 32'h01000200); end
    endtask

    task automatic test_gapped();
        wr(A_CTRL, 32'h5);
        for (int k = 0; k < 32; k++) begin
            out_valid_i = 1'b1; dout_r_i = 16'(k); dout_i_i = 16'(-k);
            if (k == 3) begin en_i = 1'b1; we_i = 4'h0; addr_i = ent(3); end
            tick(1);
            out_valid_i = 1'b0; en_i = 1'b0;
            if (k == 3) begin vectors++; if (data_o !== 32'h01030203) begin errors++; $display("FAIL rd_during_wr got %h exp %h", data_o, 32'h01030203); end end
            if (k == 30) begin vectors++; if (irq_o !== 1'b0) begin errors++; $display("FAIL gap_irq_early got %b exp %b", irq_o, 1'b0); end end
            if (k == 31) begin vectors++; if (irq_o !== 1'b1) begin errors++; $display("FAIL gap_done_timing got %b exp %b", irq_o, 1'b1); end end
            if (k < 31) begin
                if (k == 15) begin
                    rd(A_STAT, v); vectors++; if (v !== 32'h2) begin errors++; $display("FAIL gap_in_capture got %h exp %h", v, 32'h2); end
                    tick(1);
                end else tick(2);
            end
        end
        rd(A_STAT, v); vectors++; if (v !== 32'h7) begin errors++; $display("FAIL gap_status got %h exp %h", v, 32'h7); end
        rd(A_CNT, v);  vectors++; if (v !== 32'd32) begin errors++; $display("FAIL gap_count got %h exp %h", v, 32'd32); end
        rd(ent(0), v); vectors++; if (v !== 32'h0) begin errors++; $display("FAIL gap_e0 got %h exp %h", v, 32'h0); end
        rd(ent(3), v); vectors++; if (v !== 32'h0003FFFD) begin errors++; $display("FAIL gap_e3 got %h exp %h", v, 32'h0003FFFD); end
        rd(ent(5), v); vectors++; if (v !== 32'h0005FFFB) begin errors++; $display("FAIL gap_e5 got %h exp %h", v, 32'h0005FFFB); end
        rd(ent(31), v); vectors++; if (v !== 32'h001FFFE1) begin errors++; $display("FAIL gap_e31 got %h exp %h", v, 32'h001FFFE1); end
    endtask

    task automatic test_reset_mid_frame();
        wr(A_CTRL, 32'h5);
        for (int k = 0; k < 12; k++) sample(16'(16'h5000 + k), 16'(16'h6000 + k));
        rd(A_CNT, v); vectors++; if (v !== 32'd12) begin errors++; $display("FAIL mid_count12 got %h exp %h", v, 32'd12); end
        // reset lands between edges, together with sample 12
        out_valid_i = 1'b1; dout_r_i = 16'h500C; dout_i_i = 16'h600C;
        reset_n = 1'b0;
        #1;
        vectors++; if (data_o !== 32'h0) begin errors++; $display("FAIL mid_rst_data_o got %h exp %h", data_o, 32'h0); end
        vectors++; if (irq_o !== 1'b0) begin errors++; $display("FAIL mid_rst_irq got %b exp %b", irq_o, 1'b0); end
        tick(2);
        out_valid_i = 1'b0;
        reset_n = 1'b1;
        tick(1);
        rd(A_STAT, v); vectors++; if (v !== 32'h0) begin errors++; $display("FAIL mid_status got %h exp %h", v, 32'h0); end
        rd(A_CNT, v);  vectors++; if (v !== 32'h0) begin errors++; $display("FAIL mid_count got %h exp %h", v, 32'h0); end
        rd(A_CTRL, v); vectors++; if (v !== 32'h0) begin errors++; $display("FAIL mid_irqen got %h exp %h", v, 32'h0); end
        sample(16'h1111, 16'h2222);
        rd(A_STAT, v); vectors++; if (v !== 32'h8) begin errors++; $display("FAIL mid_needs_arm got %h exp %h", v, 32'h8); end
        wr(A_CTRL, 32'h5);
        for (int k = 0; k < 32; k++) sample(16'(2 * k), 16'(k));
        vectors++; if (irq_o !== 1'b1) begin errors++; $display("FAIL mid_new_irq got %b exp %b", irq_o, 1'b1); end
        rd(A_STAT, v); vectors++; if (v !== 32'h7) begin errors++; $display("FAIL mid_new_status got %h exp %h", v, 32'h7); end
        rd(A_CNT, v);  vectors++; if (v !== 32'd32) begin errors++; $display("FAIL mid_new_count got %h exp %h", v, 32'd32); end
        rd(ent(31), v); vectors++; if (v !== 32'h003E001F) begin errors++; $display("FAIL mid_new_e31 got %h exp %h", v, 32'h003E001F); end
    endtask

    initial begin
        #1;
        test_reset();
        test_full_frame();
        test_overflow();
        test_abort();
        test_priority();
        test_gapped();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
